// File: rtl/dtree_channel_scheduler.sv
// Shares one dtree classifier among CHANNELS sample streams: per-channel feature
// buffers, a round-robin grant, ready/valid feature streaming and tagged result return.
module dtree_channel_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CH_WIDTH = 2,
    parameter int FEATURES = 3,
    parameter int IN_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CH_WIDTH-1:0] in_channel,
    input  logic [IN_WIDTH-1:0] in_sample,
    output logic                in_ready,
    input  logic                dt_ready,
    output logic                dt_valid,
    output logic [IN_WIDTH-1:0] dt_sample,
    input  logic [1:0]          dt_level,
    input  logic [1:0]          dt_path,
    input  logic                dt_out_valid,
    output logic                out_valid,
    output logic [CH_WIDTH-1:0] out_channel,
    output logic [1:0]          out_level,
    output logic [1:0]          out_path
);

    localparam int CNT_W = $clog2(FEATURES + 1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(FEATURES - 1);
    localparam logic [CH_WIDTH:0]   NUM_CH   = (CH_WIDTH + 1)'(CHANNELS);
    localparam logic [CH_WIDTH-1:0] LAST_CH  = CH_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IN_WIDTH-1:0] fbuf_r [CHANNELS][FEATURES];
    logic [CNT_W-1:0]    cnt_r [CHANNELS];
    logic [CHANNELS-1:0] full_r;
    logic [CH_WIDTH-1:0] grant_r;
    logic [CH_WIDTH-1:0] last_grant_r;
    logic [CNT_W-1:0]    idx_r;
    logic [CH_WIDTH-1:0] cand_s;
    logic [CH_WIDTH-1:0] pick_s;
    logic                pick_ok_s;
    logic                wr_s;
    logic                take_s;
    logic                fire_s;
    logic                done_s;

    // Upstream may write a channel only while its buffer is not locked by full.
    always_comb begin
        if ({1'b0, in_channel} < NUM_CH) begin
            in_ready = ~full_r[in_channel];
        end else begin
            in_ready = 1'b0;
        end
    end

    assign wr_s = in_valid & in_ready;

    // Round-robin search for the first full channel after the last grant.
    always_comb begin
        cand_s    = '0;
        pick_s    = last_grant_r;
        pick_ok_s = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand_s    = CH_WIDTH'((int'(last_grant_r) + i) % CHANNELS);
            pick_s    = (!pick_ok_s && full_r[cand_s]) ? cand_s : pick_s;
            pick_ok_s = pick_ok_s | full_r[cand_s];
        end
    end

    // Scheduler next-state and dtree stream decode.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        fire_s      = 1'b0;
        done_s      = 1'b0;
        dt_valid    = 1'b0;
        dt_sample   = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_ok_s) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                dt_valid  = 1'b1;
                dt_sample = fbuf_r[grant_r][idx_r];
                if (dt_ready) begin
                    fire_s      = 1'b1;
                    state_nxt_s = (idx_r == LAST_IDX) ? ST_WAIT : ST_SEND;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (dt_out_valid) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state, grant and stream index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_CH;
            idx_r        <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                grant_r <= pick_s;
                idx_r   <= '0;
            end else if (fire_s) begin
                idx_r <= idx_r + CNT_W'(1);
            end
            if (done_s) begin
                last_grant_r <= grant_r;
            end
        end
    end

    // Per-channel buffer fill; the returning result releases the granted buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_r <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_r[c] <= '0;
            end
        end else begin
            if (wr_s) begin
                fbuf_r[in_channel][cnt_r[in_channel]] <= in_sample;
                cnt_r[in_channel] <= cnt_r[in_channel] + CNT_W'(1);
                if (cnt_r[in_channel] == LAST_IDX) begin
                    full_r[in_channel] <= 1'b1;
                end
            end
            if (done_s) begin
                full_r[grant_r] <= 1'b0;
                cnt_r[grant_r]  <= '0;
            end
        end
    end

    // Result capture; values hold until the next classification returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_level   <= 2'd0;
            out_path    <= 2'd0;
        end else begin
            out_valid <= done_s;
            if (done_s) begin
                out_channel <= grant_r;
                out_level   <= dt_level;
                out_path    <= dt_path;
            end
        end
    end

endmodule
